// File: rtl/id_stage_pkg.sv
// Shared decode constants for the ID stage.
// Opcodes, control-field layout and per-opcode control words.
package id_stage_pkg;

  localparam int OPC_W = 6;

  localparam logic [OPC_W-1:0] OP_RTYPE = 6'b000000;
  localparam logic [OPC_W-1:0] OP_LW    = 6'b100011;
  localparam logic [OPC_W-1:0] OP_SW    = 6'b101011;
  localparam logic [OPC_W-1:0] OP_BEQ   = 6'b000100;

  localparam int WB_W = 2;
  localparam int M_W  = 3;
  localparam int EX_W = 4;

  localparam int WB_REGWRITE = 1;
  localparam int WB_MEMTOREG = 0;

  localparam int M_BRANCH   = 2;
  localparam int M_MEMREAD  = 1;
  localparam int M_MEMWRITE = 0;

  localparam int EX_REGDST   = 3;
  localparam int EX_ALUOP_HI = 2;
  localparam int EX_ALUOP_LO = 1;
  localparam int EX_ALUSRC   = 0;

  typedef struct packed {
    logic [WB_W-1:0] wb;
    logic [M_W-1:0]  m;
    logic [EX_W-1:0] ex;
  } ctl_t;

  localparam ctl_t CTL_NONE  = ctl_t'(9'b00_000_0000);
  localparam ctl_t CTL_RTYPE = ctl_t'(9'b10_000_1100);
  localparam ctl_t CTL_LW    = ctl_t'(9'b11_010_0001);
  localparam ctl_t CTL_SW    = ctl_t'(9'b00_001_0001);
  localparam ctl_t CTL_BEQ   = ctl_t'(9'b00_100_0010);

endpackage

// File: rtl/id_regfile.sv
// Register file: two async read ports, one sync write port.
// Optional WB write-through: ID_STAGE_HZ_WB_BYPASS_EN.
module id_regfile
  import id_stage_pkg::*;
#(
  parameter int DATA_W   = 32,
  parameter int REG_AW   = 5,
  parameter int ZERO_REG = 1
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic [REG_AW-1:0] raddr1_i,
  input  logic [REG_AW-1:0] raddr2_i,
  output logic [DATA_W-1:0] rdata1_o,
  output logic [DATA_W-1:0] rdata2_o,
  input  logic              we_i,
  input  logic [REG_AW-1:0] waddr_i,
  input  logic [DATA_W-1:0] wdata_i
);

  localparam int NREG = 2 ** REG_AW;

  logic [DATA_W-1:0] mem_q [NREG];

  logic we_eff;
  logic zero1;
  logic zero2;
  logic byp1;
  logic byp2;

  assign we_eff = we_i
    && !((ZERO_REG != 0) && (waddr_i == '0));

  assign zero1 = (ZERO_REG != 0)
    && (raddr1_i == '0);
  assign zero2 = (ZERO_REG != 0)
    && (raddr2_i == '0);

`ifdef ID_STAGE_HZ_WB_BYPASS_EN
  assign byp1 = we_i && (waddr_i == raddr1_i);
  assign byp2 = we_i && (waddr_i == raddr2_i);
`else
  assign byp1 = 1'b0;
  assign byp2 = 1'b0;
`endif

  // Storage: cleared on reset, written by WB at the edge.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < NREG; i++) begin
        mem_q[i] <= '0;
      end
    end else if (we_eff) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  // Read port 1: hardwired zero wins over bypass.
  always_comb begin
    rdata1_o = mem_q[raddr1_i];
    if (byp1) rdata1_o = wdata_i;
    if (zero1) rdata1_o = '0;
  end

  // Read port 2: same priority as port 1.
  always_comb begin
    rdata2_o = mem_q[raddr2_i];
    if (byp2) rdata2_o = wdata_i;
    if (zero2) rdata2_o = '0;
  end

endmodule

// File: rtl/id_stage_hz.sv
// Decode stage with load-use stall, flush and ID/EX register.
// Optional feature macro: ID_STAGE_HZ_WB_BYPASS_EN.
module id_stage_hz
  import id_stage_pkg::*;
#(
  parameter int DATA_W   = 32,
  parameter int REG_AW   = 5,
  parameter int ZERO_REG = 1,
  parameter int CNT_W    = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [31:0]       ir,
  input  logic [DATA_W-1:0] npc,
  input  logic              reg_write,
  input  logic [REG_AW-1:0] write_reg,
  input  logic [DATA_W-1:0] write_data,
  input  logic              flush,
  output logic              stall,
  output logic [WB_W-1:0]   wb_ctlout,
  output logic [M_W-1:0]    m_ctlout,
  output logic [EX_W-1:0]   ex_ctlout,
  output logic [DATA_W-1:0] npcout,
  output logic [DATA_W-1:0] rdata1out,
  output logic [DATA_W-1:0] rdata2out,
  output logic [DATA_W-1:0] s_extendout,
  output logic [REG_AW-1:0] instrout_2016,
  output logic [REG_AW-1:0] instrout_1511,
  output logic              ex_valid,
  output logic [CNT_W-1:0]  stall_cnt
);

  logic [OPC_W-1:0]  opcode;
  logic [REG_AW-1:0] rs_a;
  logic [REG_AW-1:0] rt_a;
  logic [REG_AW-1:0] rd_a;
  logic [DATA_W-1:0] s_ext;
  logic [DATA_W-1:0] rd1;
  logic [DATA_W-1:0] rd2;

  ctl_t dec_ctl;
  logic dec_valid;
  logic load_use;
  logic bubble;

  ctl_t              ctl_q,   ctl_d;
  logic              valid_q, valid_d;
  logic [DATA_W-1:0] npc_q,   npc_d;
  logic [DATA_W-1:0] rd1_q,   rd1_d;
  logic [DATA_W-1:0] rd2_q,   rd2_d;
  logic [DATA_W-1:0] sx_q,    sx_d;
  logic [REG_AW-1:0] rt_q,    rt_d;
  logic [REG_AW-1:0] rdx_q,   rdx_d;
  logic [CNT_W-1:0]  cnt_q,   cnt_d;

  assign opcode = ir[31:26];
  assign rs_a   = REG_AW'(ir[25:21]);
  assign rt_a   = REG_AW'(ir[20:16]);
  assign rd_a   = REG_AW'(ir[15:11]);
  assign s_ext  = {{(DATA_W-16){ir[15]}}, ir[15:0]};

  id_regfile #(
    .DATA_W   (DATA_W),
    .REG_AW   (REG_AW),
    .ZERO_REG (ZERO_REG)
  ) u_rf (
    .clk_i    (clk),
    .rst_ni   (reset),
    .raddr1_i (rs_a),
    .raddr2_i (rt_a),
    .rdata1_o (rd1),
    .rdata2_o (rd2),
    .we_i     (reg_write),
    .waddr_i  (write_reg),
    .wdata_i  (write_data)
  );

  // Opcode decode; unknown opcodes give an invalid slot.
  always_comb begin
    dec_ctl   = CTL_NONE;
    dec_valid = 1'b0;
    unique case (1'b1)
      (opcode == OP_RTYPE): begin
        dec_ctl   = CTL_RTYPE;
        dec_valid = 1'b1;
      end
      (opcode == OP_LW): begin
        dec_ctl   = CTL_LW;
        dec_valid = 1'b1;
      end
      (opcode == OP_SW): begin
        dec_ctl   = CTL_SW;
        dec_valid = 1'b1;
      end
      (opcode == OP_BEQ): begin
        dec_ctl   = CTL_BEQ;
        dec_valid = 1'b1;
      end
      default: ;
    endcase
  end

  // A load in EX whose target feeds this instruction.
  // A load to the hardwired zero register never conflicts.
  assign load_use = ctl_q.m[M_MEMREAD]
    & valid_q
    & ((rt_q != '0) | (ZERO_REG == 0))
    & ((rt_q == rs_a) | (rt_q == rt_a));

  // A squashed instruction must not be held upstream.
  assign stall  = load_use & ~flush;
  assign bubble = flush | load_use;

  // ID/EX next state: bubble zeroes control and valid only.
  always_comb begin
    ctl_d   = bubble ? CTL_NONE : dec_ctl;
    valid_d = ~bubble & dec_valid;
    npc_d   = npc;
    rd1_d   = rd1;
    rd2_d   = rd2;
    sx_d    = s_ext;
    rt_d    = rt_a;
    rdx_d   = rd_a;
    cnt_d   = cnt_q;
    if (stall && (cnt_q != '1)) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  // ID/EX pipeline register and stall counter.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ctl_q   <= CTL_NONE;
      valid_q <= 1'b0;
      npc_q   <= '0;
      rd1_q   <= '0;
      rd2_q   <= '0;
      sx_q    <= '0;
      rt_q    <= '0;
      rdx_q   <= '0;
      cnt_q   <= '0;
    end else begin
      ctl_q   <= ctl_d;
      valid_q <= valid_d;
      npc_q   <= npc_d;
      rd1_q   <= rd1_d;
      rd2_q   <= rd2_d;
      sx_q    <= sx_d;
      rt_q    <= rt_d;
      rdx_q   <= rdx_d;
      cnt_q   <= cnt_d;
    end
  end

  assign wb_ctlout     = ctl_q.wb;
  assign m_ctlout      = ctl_q.m;
  assign ex_ctlout     = ctl_q.ex;
  assign ex_valid      = valid_q;
  assign npcout        = npc_q;
  assign rdata1out     = rd1_q;
  assign rdata2out     = rd2_q;
  assign s_extendout   = sx_q;
  assign instrout_2016 = rt_q;
  assign instrout_1511 = rdx_q;
  assign stall_cnt     = cnt_q;

endmodule

// File: tb/tb_id_stage_hz.sv
// Scoreboard bench for id_stage_hz.
// Driver queues expectations; monitor pops and compares.
module tb_id_stage_hz;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] ir;
  logic [31:0] npc;
  logic        reg_write;
  logic [4:0]  write_reg;
  logic [31:0] write_data;
  logic        flush;
  logic        stall;
  logic [1:0]  wb_ctlout;
  logic [2:0]  m_ctlout;
  logic [3:0]  ex_ctlout;
  logic [31:0] npcout;
  logic [31:0] rdata1out;
  logic [31:0] rdata2out;
  logic [31:0] s_extendout;
  logic [4:0]  instrout_2016;
  logic [4:0]  instrout_1511;
  logic        ex_valid;
  logic [15:0] stall_cnt;

  always #5 clk = ~clk;

  id_stage_hz dut (
    .clk           (clk),
    .reset         (reset),
    .ir            (ir),
    .npc           (npc),
    .reg_write     (reg_write),
    .write_reg     (write_reg),
    .write_data    (write_data),
    .flush         (flush),
    .stall         (stall),
    .wb_ctlout     (wb_ctlout),
    .m_ctlout      (m_ctlout),
    .ex_ctlout     (ex_ctlout),
    .npcout        (npcout),
    .rdata1out     (rdata1out),
    .rdata2out     (rdata2out),
    .s_extendout   (s_extendout),
    .instrout_2016 (instrout_2016),
    .instrout_1511 (instrout_1511),
    .ex_valid      (ex_valid),
    .stall_cnt     (stall_cnt)
  );

  localparam logic [8:0] C_0   = 9'b00_000_0000;
  localparam logic [8:0] C_R   = 9'b10_000_1100;
  localparam logic [8:0] C_LW  = 9'b11_010_0001;
  localparam logic [8:0] C_SW  = 9'b00_001_0001;
  localparam logic [8:0] C_BEQ = 9'b00_100_0010;
  localparam logic [31:0] BAD  = 32'hFC00_0000;

`ifdef ID_STAGE_HZ_WB_BYPASS_EN
  localparam logic [31:0] BYP = 32'h0000_1234;
`else
  localparam logic [31:0] BYP = 32'h0000_0000;
`endif

  typedef struct {
    string       nm;
    bit          dat;
    logic        st;
    logic [8:0]  ctl;
    logic        v;
    logic [15:0] cnt;
    logic [31:0] npc;
    logic [31:0] r1;
    logic [31:0] r2;
    logic [31:0] sx;
    logic [4:0]  a;
    logic [4:0]  b;
  } exp_t;

  exp_t q[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  bit   busy  = 1'b0;

  function automatic void cmp(
    input string nm,
    input logic [31:0] act,
    input logic [31:0] exp
  );
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endfunction

  function automatic exp_t mk(
    input string nm, input logic st,
    input logic [8:0] ctl, input logic v,
    input logic [15:0] cnt, input bit dat,
    input logic [31:0] pc, input logic [31:0] r1,
    input logic [31:0] r2, input logic [31:0] sx,
    input logic [4:0] a, input logic [4:0] b
  );
    exp_t e;
    e.nm = nm; e.st = st; e.ctl = ctl; e.v = v;
    e.cnt = cnt; e.dat = dat; e.npc = pc;
    e.r1 = r1; e.r2 = r2; e.sx = sx;
    e.a = a; e.b = b;
    return e;
  endfunction

  function automatic exp_t bub(
    input string nm, input logic st,
    input logic [15:0] cnt
  );
    return mk(nm, st, C_0, 1'b0, cnt, 1'b0,
              0, 0, 0, 0, 5'd0, 5'd0);
  endfunction

  task automatic drv(
    input logic [31:0] i, input logic [31:0] pc,
    input logic rw, input logic [4:0] wr,
    input logic [31:0] wd, input logic fl,
    input exp_t e
  );
    @(posedge clk);
    #2;
    ir = i; npc = pc; reg_write = rw;
    write_reg = wr; write_data = wd; flush = fl;
    q.push_back(e);
  endtask

  // Monitor: stall checked in the issue cycle, ID/EX after the edge.
  initial begin : mon
    exp_t e;
    forever begin
      @(negedge clk);
      if (q.size() != 0) begin
        e = q.pop_front();
        busy = 1'b1;
        cmp({e.nm, ".stall"}, 32'(stall), 32'(e.st));
        @(posedge clk);
        #1;
        cmp({e.nm, ".ctl"},
            32'({wb_ctlout, m_ctlout, ex_ctlout}),
            32'(e.ctl));
        cmp({e.nm, ".valid"}, 32'(ex_valid), 32'(e.v));
        cmp({e.nm, ".cnt"}, 32'(stall_cnt), 32'(e.cnt));
        if (e.dat) begin
          cmp({e.nm, ".npc"}, npcout, e.npc);
          cmp({e.nm, ".rd1"}, rdata1out, e.r1);
          cmp({e.nm, ".rd2"}, rdata2out, e.r2);
          cmp({e.nm, ".sx"}, s_extendout, e.sx);
          cmp({e.nm, ".rt"}, 32'(instrout_2016), 32'(e.a));
          cmp({e.nm, ".rd"}, 32'(instrout_1511), 32'(e.b));
        end
        busy = 1'b0;
      end
    end
  end

  task automatic drain(input string nm);
    int k;
    k = 0;
    while ((q.size() != 0 || busy) && k < 50) begin
      @(posedge clk);
      k++;
    end
    if (q.size() != 0 || busy) begin
      n_cmp++;
      n_bad++;
      $display("FAIL %s: drain timeout, %0d left", nm, q.size());
    end
    @(negedge clk);
  endtask

  initial begin
    reset = 1'b0; ir = BAD; npc = 0; flush = 1'b0;
    reg_write = 1'b0; write_reg = 0; write_data = 0;
    repeat (3) @(posedge clk);
    #1;
    cmp("rst.stall", 32'(stall), 0);
    cmp("rst.ctl", 32'({wb_ctlout, m_ctlout, ex_ctlout}), 0);
    cmp("rst.valid", 32'(ex_valid), 0);
    cmp("rst.cnt", 32'(stall_cnt), 0);
    cmp("rst.npc", npcout, 0);
    cmp("rst.rd1", rdata1out, 0);
    cmp("rst.sx", s_extendout, 0);
    cmp("rst.rt", 32'(instrout_2016), 0);
    @(negedge clk);
    reset = 1'b1;

    drv(BAD, 32'h0, 1, 5'd1, 32'd5, 0, bub("wr1", 0, 0));
    drv(BAD, 32'h0, 1, 5'd2, 32'd7, 0, bub("wr2", 0, 0));
    drv(32'h00221820, 32'h100, 0, 0, 0, 0,
        mk("rtype", 0, C_R, 1, 0, 1, 32'h100,
           5, 7, 32'h1820, 5'd2, 5'd3));
    drv(32'h8C220004, 32'h104, 0, 0, 0, 0,
        mk("lw", 0, C_LW, 1, 0, 1, 32'h104,
           5, 7, 32'h4, 5'd2, 5'd0));
    drv(32'h00421820, 32'h108, 0, 0, 0, 0,
        bub("lu_stall", 1, 1));
    drv(32'h00421820, 32'h108, 0, 0, 0, 0,
        mk("lu_issue", 0, C_R, 1, 1, 1, 32'h108,
           7, 7, 32'h1820, 5'd2, 5'd3));
    drv(32'h8C220004, 32'h10C, 0, 0, 0, 0,
        mk("lw2", 0, C_LW, 1, 1, 1, 32'h10C,
           5, 7, 32'h4, 5'd2, 5'd0));
    drv(32'h00421820, 32'h110, 0, 0, 0, 1,
        bub("lu_flush", 0, 1));
    drv(BAD, 32'h0, 1, 5'd0, 32'hDEADBEEF, 0,
        bub("wr0", 0, 1));
    drv(32'h8C058000, 32'h114, 0, 0, 0, 0,
        mk("r0_imm", 0, C_LW, 1, 1, 1, 32'h114,
           0, 0, 32'hFFFF8000, 5'd5, 5'd16));
    drv(32'h00803020, 32'h200, 1, 5'd4, 32'h1234, 0,
        mk("bypass", 0, C_R, 1, 1, 1, 32'h200,
           BYP, 0, 32'h3020, 5'd0, 5'd6));
    drv(32'h00803020, 32'h204, 0, 0, 0, 0,
        mk("r4_after", 0, C_R, 1, 1, 1, 32'h204,
           32'h1234, 0, 32'h3020, 5'd0, 5'd6));
    drv(32'h1022FFFF, 32'h208, 0, 0, 0, 0,
        mk("beq", 0, C_BEQ, 1, 1, 1, 32'h208,
           5, 7, 32'hFFFFFFFF, 5'd2, 5'd31));
    drv(32'hAC220008, 32'h20C, 0, 0, 0, 0,
        mk("sw", 0, C_SW, 1, 1, 1, 32'h20C,
           5, 7, 32'h8, 5'd2, 5'd0));
    drv(32'h8C200000, 32'h210, 0, 0, 0, 0,
        mk("lw_r0", 0, C_LW, 1, 1, 1, 32'h210,
           5, 0, 32'h0, 5'd0, 5'd0));
    drv(32'h00001820, 32'h214, 0, 0, 0, 0,
        mk("no_lu_r0", 0, C_R, 1, 1, 1, 32'h214,
           0, 0, 32'h1820, 5'd0, 5'd3));
    drv(32'h8C230000, 32'h218, 0, 0, 0, 0,
        mk("lw_r3", 0, C_LW, 1, 1, 1, 32'h218,
           5, 0, 32'h0, 5'd3, 5'd0));
    drv(32'h00602020, 32'h21C, 0, 0, 0, 0,
        bub("lu_rs", 1, 2));
    drv(32'h00602020, 32'h21C, 0, 0, 0, 0,
        mk("lu_rs_iss", 0, C_R, 1, 2, 1, 32'h21C,
           0, 0, 32'h2020, 5'd0, 5'd4));
    drv(BAD, 32'h0, 0, 0, 0, 0, bub("idle", 0, 2));
    drain("main");

    @(posedge clk);
    #3;
    reset = 1'b0;
    #1;
    cmp("arst.valid", 32'(ex_valid), 0);
    cmp("arst.cnt", 32'(stall_cnt), 0);
    cmp("arst.ctl", 32'({wb_ctlout, m_ctlout, ex_ctlout}), 0);
    cmp("arst.npc", npcout, 0);
    @(negedge clk);
    reset = 1'b1;

    drv(32'h00221820, 32'h300, 0, 0, 0, 0,
        mk("post_rst", 0, C_R, 1, 0, 1, 32'h300,
           0, 0, 32'h1820, 5'd2, 5'd3));
    drv(BAD, 32'h0, 0, 0, 0, 0, bub("idle2", 0, 0));
    drain("post");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/id_stage_hz.md
Name: id_stage_hz

Overview:
- Parametrised instruction-decode stage: decodes the opcode, reads the register file and sign-extends the immediate.
- Registers the result into an internal ID/EX pipeline register.
- Adds what the previous ID stage lacked: load-use hazard detection with stall, flush (bubble insertion), a valid bit and a stall counter.
- Sits between the IF/ID register (upstream) and the EX stage (downstream).

Parameters:
- DATA_W, 32, datapath and register width.
- REG_AW, 5, register address width; register file holds 2**REG_AW entries.
- ZERO_REG, 1, 1 = register 0 reads as zero and writes to it are ignored; 0 = ordinary register.
- CNT_W, 16, stall counter width.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-low reset.
- ir  in  32  instruction from IF/ID.
- npc  in  DATA_W  next PC from IF/ID.
- reg_write  in  1  WB-stage write enable.
- write_reg  in  REG_AW  WB-stage destination register.
- write_data  in  DATA_W  WB-stage write data.
- flush  in  1  branch taken: squash the instruction currently in ID.
- stall  out  1  hold PC and IF/ID (combinational).
- wb_ctlout  out  2  WB control, {RegWrite, MemtoReg}.
- m_ctlout  out  3  MEM control, {Branch, MemRead, MemWrite}.
- ex_ctlout  out  4  EX control, {RegDst, ALUOp[1:0], ALUSrc}.
- npcout  out  DATA_W  registered npc.
- rdata1out  out  DATA_W  registered rs data.
- rdata2out  out  DATA_W  registered rt data.
- s_extendout  out  DATA_W  registered sign-extended ir[15:0].
- instrout_2016  out  REG_AW  registered ir[20:16].
- instrout_1511  out  REG_AW  registered ir[15:11].
- ex_valid  out  1  ID/EX slot holds a real instruction.
- stall_cnt  out  CNT_W  saturating count of stall cycles.

Behaviour:
- Reset (reset=0, asynchronous): every register-file entry, every ID/EX output, ex_valid and stall_cnt are 0.
- Decode (combinational), as {WB, M, EX}:
  - opcode 000000 (R-type) -> 10, 000, 1100
  - opcode 100011 (lw) -> 11, 010, 0001
  - opcode 101011 (sw) -> 00, 001, 0001
  - opcode 000100 (beq) -> 00, 100, 0010
  - any other opcode -> all 0, and the slot is not valid.
- Sign extension: s_ext = {(DATA_W-16){ir[15]}, ir[15:0]}.
- Register file:
  - Two combinational read ports at ir[25:21] and ir[20:16] (low REG_AW bits).
  - One synchronous write port, written at the rising edge when reg_write=1.
  - With ZERO_REG=1, a write to register 0 is dropped and a read of register 0 returns 0.
- Hazard detection: load_use = m_ctlout[1] & ex_valid & (instrout_2016 != 0 or ZERO_REG=0) & (instrout_2016 == rs or instrout_2016 == rt).
- stall = load_use & ~flush.
- ID/EX update at each rising edge (latency 1 cycle):
  - flush=1 or load_use=1: control outputs and ex_valid load 0 (bubble). Data fields still load the current values; they are don't-care.
  - Otherwise: all fields load the decode, read and extend results; ex_valid = 1 if the opcode is recognised, else 0.
- Flush and load_use in the same cycle: bubble is inserted and stall=0, because the squashed instruction must not be held.
- stall_cnt increments on each cycle with stall=1 and saturates at all-ones.
- A reset asserted mid-operation clears state immediately, independent of clk.

Optional Feature:
- Macro: ID_STAGE_HZ_WB_BYPASS_EN.
- Defined: write-through bypass. On each read port, if reg_write=1, write_reg matches the read address, and the address is not 0 (when ZERO_REG=1), the read returns write_data in the same cycle. A WB write and an ID read of the same register in one cycle therefore yield the new value.
- Undefined: the read returns the stored value, so a same-cycle write becomes visible one cycle later.

Decomposition:
- Package id_stage_pkg holds:
  - opcode constants OP_RTYPE, OP_LW, OP_SW, OP_BEQ;
  - control-field width constants (2/3/4);
  - bit-index constants for RegWrite, MemRead, etc.;
  - per-opcode control value constants.
- One sub-module, id_regfile, parametrised by DATA_W, REG_AW and ZERO_REG. It contains the bypass logic.
- Decode, hazard detection and the ID/EX register stay in the top module.

Test Plan:
- Reset: hold reset=0, toggle clk -> all outputs 0, stall=0, stall_cnt=0.
- R-type: write r1=5 and r2=7, then apply ir=0x00221820 -> next cycle wb=10, m=000, ex=1100, rdata1out=5, rdata2out=7, instrout_1511=3, ex_valid=1.
- Load-use:
  - Apply lw r2,4(r1) (ir=0x8C220004), then add r3,r2,r2 -> stall=1 for exactly one cycle, ID/EX controls become 0 with ex_valid=0, stall_cnt=1.
  - The held add then issues on the following cycle.
- Flush with simultaneous hazard: same sequence but flush=1 in the hazard cycle -> stall=0, bubble inserted, stall_cnt unchanged.
- Zero register and immediate:
  - Write 0xDEADBEEF to r0 -> reading r0 returns 0 (ZERO_REG=1).
  - Apply ir with imm=0x8000 -> s_extendout=0xFFFF8000.
- Bypass: same cycle reg_write=1, write_reg=4, write_data=0x1234, ir reads rs=4 -> rdata1out=0x1234 with the macro defined, old value (0) without it.
